parking_slot_ctrl: RTL and testbench

PARKING_SLOT_CTRL -- requirements
Module: parking_slot_ctrl

---
 rtl/parking_slot_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_parking_slot_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_slot_ctrl.sv
// -----------------------------------------------------------------------------
// parking_slot_ctrl
// 16-slot parking controller. Entry and exit requests are arbitrated
// round-robin, checked against a table of parked vehicle numbers, and answered
// with a one-cycle ack (plus err on rejection). A granted request opens the
// matching gate for GATE_CYCLES clocks.
//
// Optional feature macro: PARK_STATS_EN
//   defined   -> rej_cnt counts rejections, saturating at 255
//   undefined -> rej_cnt is tied to 0 and no counter is built
// -----------------------------------------------------------------------------
module parking_slot_ctrl #(
    parameter int             N           = 4,
    parameter logic [N-1:0]   PASSWORD    = 4'b0011,
    parameter int             GATE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ent_req,
    input  logic [N-1:0] ent_vn,
    input  logic [N-1:0] ent_pw,
    input  logic         ext_req,
    input  logic [N-1:0] ext_vn,
    output logic         ent_ack,
    output logic         ext_ack,
    output logic         err,
    output logic         ent_gate,
    output logic         ext_gate,
    output logic [3:0]   slot,
    output logic [4:0]   count,
    output logic         full,
    output logic         empty,
    output logic [7:0]   rej_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        GATE   = 2'd2,
        REJECT = 2'd3
    } state_t;

    localparam logic [7:0] GATE_LAST = 8'(GATE_CYCLES - 1);

    state_t       state_q, state_d;

    // Latched request
    logic         req_ext_q;
    logic [N-1:0] vn_q;
    logic [N-1:0] pw_q;
    logic         last_ext_q;   // type served most recently (1 = exit)

    // Slot table
    logic [15:0]  tbl_valid_q;
    logic [N-1:0] tbl_vn_q [16];
    logic [4:0]   count_q;
    logic [3:0]   slot_q;
    logic [7:0]   gate_cnt_q;

    // Lookup / decision signals
    logic         hit;
    logic [3:0]   hit_idx;
    logic [3:0]   free_idx;
    logic         grant;
    logic         pick_ext;
    logic         first_gate;

    assign full  = (count_q == 5'd16);
    assign empty = (count_q == 5'd0);
    assign count = count_q;
    assign slot  = slot_q;

    // Round-robin choice: exit wins unless entry is also pending and exit went last
    assign pick_ext = ext_req && (!ent_req || !last_ext_q);

    // Table search: matching valid entry and lowest-index free slot
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        hit      = 1'b0;
        hit_idx  = 4'd0;
        free_idx = 4'd0;
        // Descending scan so the last write is the lowest index
        for (int i = 15; i >= 0; i--) begin
            if (tbl_valid_q[i] && (tbl_vn_q[i] == vn_q)) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
            end
            if (!tbl_valid_q[i]) begin
                free_idx = 4'(i);
            end
        end
    end

    // Accept/reject decision for the latched request
    always_comb begin
        if (req_ext_q) begin
            grant = hit;
        end else begin
            grant = (pw_q == PASSWORD) && !full && !hit;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ent_req || ext_req) state_d = CHECK;
            CHECK:   state_d = grant ? GATE : REJECT;
            GATE:    if (gate_cnt_q == 8'd0) state_d = IDLE;
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; ack is the first GATE cycle or the REJECT cycle
    always_comb begin
        first_gate = (state_q == GATE) && (gate_cnt_q == GATE_LAST);
        ent_ack    = (first_gate || (state_q == REJECT)) && !req_ext_q;
        ext_ack    = (first_gate || (state_q == REJECT)) &&  req_ext_q;
        err        = (state_q == REJECT);
        ent_gate   = (state_q == GATE) && !req_ext_q;
        ext_gate   = (state_q == GATE) &&  req_ext_q;
    end

    // Capture the winning request while idle and remember which type was served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ext_q  <= 1'b0;
            vn_q       <= '0;
            pw_q       <= '0;
            last_ext_q <= 1'b0;
        end else if ((state_q == IDLE) && (ent_req || ext_req)) begin
            req_ext_q  <= pick_ext;
            vn_q       <= pick_ext ? ext_vn : ent_vn;
            pw_q       <= ent_pw;
            last_ext_q <= pick_ext;
        end
    end

    // Gate hold timer: loaded on the decision, counts down through GATE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt_q <= 8'd0;
        end else if (state_q == CHECK) begin
            gate_cnt_q <= GATE_LAST;
        end else if ((state_q == GATE) && (gate_cnt_q != 8'd0)) begin
            gate_cnt_q <= gate_cnt_q - 8'd1;
        end
    end

    // Valid bits, occupancy and reported slot, updated as GATE is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_valid_q <= '0;
            count_q     <= 5'd0;
            slot_q      <= 4'd0;
        end else if (state_q == CHECK) begin
            if (!grant) begin
                slot_q <= 4'd0;
            end else if (req_ext_q) begin
                tbl_valid_q[hit_idx] <= 1'b0;
                count_q              <= count_q - 5'd1;
                slot_q               <= hit_idx;
            end else begin
                tbl_valid_q[free_idx] <= 1'b1;
                count_q               <= count_q + 5'd1;
                slot_q                <= free_idx;
            end
        end
    end

    // Vehicle numbers stored alongside the valid bits
    always_ff @(posedge clk) begin
        // NOTE: the vehicle-number storage has no reset; its contents are ignored until the valid bit is set.
        if ((state_q == CHECK) && grant && !req_ext_q) begin
            tbl_vn_q[free_idx] <= vn_q;
        end
    end

`ifdef PARK_STATS_EN
    logic [7:0] rej_cnt_q;

    // Saturating rejection counter, bumped as REJECT is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rej_cnt_q <= 8'd0;
        end else if ((state_q == CHECK) && !grant && (rej_cnt_q != 8'hFF)) begin
            rej_cnt_q <= rej_cnt_q + 8'd1;
        end
    end

    assign rej_cnt = rej_cnt_q;
`else
    assign rej_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_parking_slot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_slot_ctrl
// Directed stimulus with a scoreboard: each request pushes its hand-computed
// response into a queue, and a monitor pops and compares on every ack.
// -----------------------------------------------------------------------------
module tb_parking_slot_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ent_req;
    logic [3:0] ent_vn;
    logic [3:0] ent_pw;
    logic       ext_req;
    logic [3:0] ext_vn;
    logic       ent_ack;
    logic       ext_ack;
    logic       err;
    logic       ent_gate;
    logic       ext_gate;
    logic [3:0] slot;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic [7:0] rej_cnt;

    parking_slot_ctrl #(
        .N           (4),
        .PASSWORD    (4'b0011),
        .GATE_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ent_req  (ent_req),
        .ent_vn   (ent_vn),
        .ent_pw   (ent_pw),
        .ext_req  (ext_req),
        .ext_vn   (ext_vn),
        .ent_ack  (ent_ack),
        .ext_ack  (ext_ack),
        .err      (err),
        .ent_gate (ent_gate),
        .ext_gate (ext_gate),
        .slot     (slot),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .rej_cnt  (rej_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_ext;
        bit         err;
        logic [3:0] slot;
        logic [4:0] count;
        logic [7:0] rej;
    } exp_t;

    exp_t exp_q[$];
    int   m_count;
    int   m_rej;
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue the response the next ack must show
    task automatic expect_resp(input bit is_ext, input bit e_err, input logic [3:0] e_slot);
        exp_t e;
        if (!e_err) m_count = is_ext ? m_count - 1 : m_count + 1;
        else if (m_rej < 255) m_rej++;
        e.is_ext = is_ext;
        e.err    = e_err;
        e.slot   = e_slot;
        e.count  = 5'(m_count);
`ifdef PARK_STATS_EN
        e.rej    = 8'(m_rej);
`else
        e.rej    = 8'd0;
`endif
        exp_q.push_back(e);
    endtask

    // Raise a request, hold it until its ack, optionally check latency and gate length
    task automatic drive_req(input bit is_ext, input logic [3:0] vn, input logic [3:0] pw,
                             input bit chk_lat, input bit chk_gate);
        int waited;
        int gcnt;
        bit got;
        @(negedge clk);
        if (is_ext) begin
            ext_req = 1'b1;
            ext_vn  = vn;
        end else begin
            ent_req = 1'b1;
            ent_vn  = vn;
            ent_pw  = pw;
        end
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 64) begin
            @(negedge clk);
            waited++;
            got = is_ext ? ext_ack : ent_ack;
        end
        if (is_ext) ext_req = 1'b0;
        else        ent_req = 1'b0;
        if (!got) begin
            check("ack_timeout", 32'(got), 32'd1);
        end else begin
            if (chk_lat) check("ack_latency", 32'(waited), 32'd2);
            if (chk_gate) begin
                gcnt = 0;
                while ((is_ext ? ext_gate : ent_gate) && gcnt < 300) begin
                    gcnt++;
                    @(negedge clk);
                end
                check("gate_cycles", 32'(gcnt), 32'd4);
            end
        end
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        ent_req = 1'b0;
        ext_req = 1'b0;
        m_count = 0;
        m_rej   = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one-gate rule every cycle, scoreboard compare on every ack
    always @(negedge clk) begin
        if (rst_n) begin
            check("one_gate", 32'(ent_gate && ext_gate), 32'd0);
            if (ent_ack || ext_ack) begin
                if (exp_q.size() == 0) begin
                    check("ack_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_type", {30'd0, ent_ack, ext_ack}, e.is_ext ? 32'd1 : 32'd2);
                    check("err", 32'(err), 32'(e.err));
                    if (!e.err) check("slot", 32'(slot), 32'(e.slot));
                    check("count", 32'(count), 32'(e.count));
                    check("rej_cnt", 32'(rej_cnt), 32'(e.rej));
                    check("gate_open", 32'(e.is_ext ? ext_gate : ent_gate), 32'(!e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ent_vn   = '0;
        ent_pw   = '0;
        ext_vn   = '0;
        apply_reset();
        rst_n = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_count",    32'(count),    32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_ent_gate", 32'(ent_gate), 32'd0);
        check("rst_ext_gate", 32'(ext_gate), 32'd0);
        check("rst_ent_ack",  32'(ent_ack),  32'd0);
        check("rst_ext_ack",  32'(ext_ack),  32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_slot",     32'(slot),     32'd0);
        check("rst_rej_cnt",  32'(rej_cnt),  32'd0);
        rst_n = 1'b1;

        // Basic entry: vn 5 gets slot 0
        expect_resp(1'b0, 1'b0, 4'd0);
        drive_req(1'b0, 4'd5, 4'd3, 1'b1, 1'b1);

        // Wrong password
        expect_resp(1'b0, 1'b1, 4'd0);
        drive_req(1'b0, 4'd6, 4'd2, 1'b1, 1'b0);

        // Exit of an unparked vehicle, then entry of an already-parked one
        expect_resp(1'b1, 1'b1, 4'd0);
        drive_req(1'b1, 4'd9, 4'd0, 1'b1, 1'b0);
        expect_resp(1'b0, 1'b1, 4'd0);
        drive_req(1'b0, 4'd5, 4'd3, 1'b1, 1'b0);

        // Exit vn 5 frees slot 0
        expect_resp(1'b1, 1'b0, 4'd0);
        drive_req(1'b1, 4'd5, 4'd0, 1'b1, 1'b1);
        check("empty_after_exit", 32'(empty), 32'd1);

        // Fill all sixteen slots in order
        for (int i = 0; i < 16; i++) begin
            expect_resp(1'b0, 1'b0, 4'(i));
            drive_req(1'b0, 4'(i), 4'd3, 1'b1, 1'b1);
        end
        check("full_at_16",  32'(full),  32'd1);
        check("empty_at_16", 32'(empty), 32'd0);

        // Seventeenth entry rejected
        expect_resp(1'b0, 1'b1, 4'd0);
        drive_req(1'b0, 4'd7, 4'd3, 1'b1, 1'b0);

        // Free slot 3, then a new entry reuses it
        expect_resp(1'b1, 1'b0, 4'd3);
        drive_req(1'b1, 4'd3, 4'd0, 1'b1, 1'b1);
        check("not_full_15", 32'(full), 32'd0);
        expect_resp(1'b0, 1'b0, 4'd3);
        drive_req(1'b0, 4'd3, 4'd3, 1'b1, 1'b1);
        check("count_16", 32'(count), 32'd16);

        // Collision right after reset: exit first (rejected), then entry
        apply_reset();
        check("count_cleared", 32'(count), 32'd0);
        expect_resp(1'b1, 1'b1, 4'd0);
        expect_resp(1'b0, 1'b0, 4'd0);
        fork
            drive_req(1'b1, 4'd9, 4'd0, 1'b0, 1'b0);
            drive_req(1'b0, 4'd2, 4'd3, 1'b0, 1'b1);
        join

        // Collision after entry went last: exit wins; then exit re-raised while
        // entry waits, so entry wins the next collision
        expect_resp(1'b1, 1'b0, 4'd0);
        expect_resp(1'b0, 1'b0, 4'd0);
        expect_resp(1'b1, 1'b0, 4'd0);
        fork
            begin
                drive_req(1'b1, 4'd2, 4'd0, 1'b0, 1'b0);
                drive_req(1'b1, 4'd4, 4'd0, 1'b0, 1'b1);
            end
            drive_req(1'b0, 4'd4, 4'd3, 1'b0, 1'b1);
        join

        // Reset in the second gate cycle closes the gate at once
        expect_resp(1'b0, 1'b0, 4'd0);
        drive_req(1'b0, 4'd5, 4'd3, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        m_count = 0;
        m_rej   = 0;
        #1;
        check("async_gate_drop", 32'(ent_gate), 32'd0);
        check("async_count",     32'(count),    32'd0);
        check("async_empty",     32'(empty),    32'd1);
        check("async_ack",       32'(ent_ack),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back in IDLE: a fresh entry gets the normal two-cycle latency
        expect_resp(1'b0, 1'b0, 4'd0);
        drive_req(1'b0, 4'd5, 4'd3, 1'b1, 1'b1);

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
